// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice path: sine table geometry,
// sample width and the oscillator handshake states.
package synth_pkg;

  localparam int TABLE_LEN = 48000;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 24;

  // Table length at address width, used for range checks on phase and step.
  localparam logic [ADDR_W-1:0] TABLE_LEN_A = ADDR_W'(TABLE_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    VALID = 2'd3
  } osc_state_t;

endpackage : synth_pkg

// File: rtl/phase_wrap.sv
// Next-phase calculation: clamps an out-of-range step to zero and wraps the
// sum back into 0..TABLE_LEN-1. Purely combinational.
module phase_wrap
  import synth_pkg::*;
(
  input  logic [ADDR_W-1:0] i_phase,
  input  logic [ADDR_W-1:0] i_freq,
  output logic [ADDR_W-1:0] o_next_phase
);

  logic [ADDR_W-1:0] w_f_eff;
  logic [ADDR_W:0]   w_sum;
  logic              w_over;

  assign w_f_eff = (i_freq < TABLE_LEN_A) ? i_freq : '0;
  assign w_sum   = {1'b0, i_phase} + {1'b0, w_f_eff};
  assign w_over  = (w_sum >= {1'b0, TABLE_LEN_A});

  // When wrapping, the true result is below TABLE_LEN, so the low ADDR_W bits
  // of the subtraction are exact and the carry bit can be dropped.
  assign o_next_phase = w_sum[ADDR_W-1:0] - (w_over ? TABLE_LEN_A : '0);

endmodule : phase_wrap

// File: rtl/sine_osc.sv
// Phase-accumulator oscillator: addresses an external registered sine ROM and
// streams samples to the codec writer over a valid/ready handshake.
module sine_osc
  import synth_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic        [ADDR_W-1:0] freq,
  output logic        [ADDR_W-1:0] rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic signed [DATA_W-1:0] sample,
  output logic                     sample_valid,
  input  logic                     sample_ready
);

  osc_state_t                r_state;
  logic        [ADDR_W-1:0]  r_phase;
  logic signed [DATA_W-1:0]  r_sample;
  logic                      r_valid;
  logic        [ADDR_W-1:0]  w_next_phase;
  logic                      w_xfer;

  phase_wrap u_phase_wrap (
    .i_phase      (r_phase),
    .i_freq       (freq),
    .o_next_phase (w_next_phase)
  );

  assign w_xfer = (r_state == VALID) && sample_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // sees pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) r_state <= FETCH;
        end
        FETCH: begin
          // ROM captures rom_addr at the end of this cycle.
          r_state <= LOAD;
        end
        LOAD: begin
          r_sample <= rom_data;
          r_valid  <= 1'b1;
          r_state  <= VALID;
        end
        VALID: begin
          if (w_xfer) begin
            r_phase <= w_next_phase;
            r_valid <= 1'b0;
            r_state <= enable ? FETCH : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr     = r_phase;
  assign sample       = r_sample;
  assign sample_valid = r_valid;

endmodule : sine_osc

// File: tb/tb_sine_osc.sv
// Directed bench for sine_osc with an identity ROM model (sample == phase).
module tb_sine_osc;

  localparam int AW = 17;
  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic        [AW-1:0] freq;
  logic        [AW-1:0] rom_addr;
  logic signed [DW-1:0] rom_data = '0;
  logic signed [DW-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;

  int n_tests = 0;
  int n_fail  = 0;

  sine_osc dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .freq         (freq),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  always #5 clk = ~clk;

  // Registered identity ROM, one-cycle latency.
  always @(posedge clk) rom_data <= {7'b0, rom_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    sample_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    freq = '0;
    sample_ready = 1'b0;

    // Reset held for 3 cycles, then released with enable low.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_valid", 32'(sample_valid), 32'd0);
      check("idle_addr", 32'(rom_addr), 32'd0);
    end

    // Basic tone: one sample every 3 cycles, first valid 2 cycles after E.
    freq = 17'd440;
    sample_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("tone_v0", 32'(sample_valid), 32'd0);
      step();
      check("tone_v1", 32'(sample_valid), 32'd0);
      step();
      check("tone_v2", 32'(sample_valid), 32'd1);
      check("tone_sample", 32'(sample), 32'(k * 440));
    end

    // Wrap with a large step.
    do_reset();
    freq = 17'd30000;
    sample_ready = 1'b1;
    enable = 1'b1;
    begin
      int exp_w[6] = '{0, 30000, 12000, 42000, 24000, 6000};
      for (int k = 0; k < 6; k++) begin
        wait_valid(10);
        check("wrap_sample", 32'(sample), 32'(exp_w[k]));
      end
    end

    // Step of 1000 returns to phase 0 after exactly 48 transfers.
    do_reset();
    freq = 17'd1000;
    sample_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 48; k++) begin
      wait_valid(10);
      check("k1000_sample", 32'(sample), 32'(k * 1000));
    end
    step();
    check("k1000_addr_wrap", 32'(rom_addr), 32'd0);

    // Backpressure: everything holds while ready is low.
    do_reset();
    freq = 17'd100;
    enable = 1'b1;
    wait_valid(10);
    check("bp_first", 32'(sample), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 32'(sample_valid), 32'd1);
      check("bp_sample", 32'(sample), 32'd0);
      check("bp_addr", 32'(rom_addr), 32'd0);
    end
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    check("bp_xfer_valid", 32'(sample_valid), 32'd0);
    check("bp_xfer_addr", 32'(rom_addr), 32'd100);
    wait_valid(10);
    check("bp_next", 32'(sample), 32'd100);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_one_xfer", 32'(sample), 32'd100);
      check("bp_one_valid", 32'(sample_valid), 32'd1);
    end

    // Out-of-range step repeats the current phase.
    freq = 17'd50000;
    sample_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(10);
      check("oor_sample", 32'(sample), 32'd100);
      check("oor_addr", 32'(rom_addr), 32'd100);
    end

    // Enable dropped in FETCH: one sample finishes, then IDLE with phase kept.
    do_reset();
    freq = 17'd200;
    enable = 1'b1;
    step();
    enable = 1'b0;
    wait_valid(10);
    check("en_drop_sample", 32'(sample), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_drop_hold", 32'(sample_valid), 32'd1);
    end
    sample_ready = 1'b1;
    step();
    check("en_drop_xfer", 32'(sample_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_idle_valid", 32'(sample_valid), 32'd0);
      check("en_idle_addr", 32'(rom_addr), 32'd200);
    end
    enable = 1'b1;
    wait_valid(10);
    check("en_resume", 32'(sample), 32'd200);

    // Reset asserted during LOAD clears outputs immediately.
    do_reset();
    freq = 17'd500;
    sample_ready = 1'b1;
    enable = 1'b1;
    wait_valid(10);
    wait_valid(10);
    check("rl_pre", 32'(sample), 32'd500);
    step();
    step();
    check("rl_in_load_sample", 32'(sample), 32'd500);
    check("rl_in_load_addr", 32'(rom_addr), 32'd1000);
    reset_n = 1'b0;
    #1;
    check("rl_async_valid", 32'(sample_valid), 32'd0);
    check("rl_async_sample", 32'(sample), 32'd0);
    check("rl_async_addr", 32'(rom_addr), 32'd0);
    step();
    check("rl_hold_valid", 32'(sample_valid), 32'd0);
    enable = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rl_no_spurious", 32'(sample_valid), 32'd0);
      check("rl_sample_zero", 32'(sample), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sine_osc

// File: doc/sine_osc.md
# sine_osc

Phase-accumulator oscillator that drives the synth's 48000-entry sine ROM (`sine`, 1-cycle registered read) and streams the returned 24-bit signed samples to the audio-codec writer over a valid/ready handshake. With a table length equal to the 48 kHz sample rate, a phase step of N produces an N Hz tone. The block sits between the note/frequency control logic and the codec output path. The parent wires `rom_addr`/`rom_data` to a `sine` instance.

## Interface
- `TABLE_LEN`, 48000: number of addressable phase steps; phase range 0..TABLE_LEN-1.
- `ADDR_W`, 17: phase/address width.
- `DATA_W`, 24: sample width.

- `clk`  in  1  system clock (50 MHz); all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; when low, the oscillator idles after finishing any pending handshake.
- `freq`  in  ADDR_W  phase step per sample (Hz); sampled at each phase advance.
- `rom_addr`  out  ADDR_W  ROM index; equals the phase register.
- `rom_data`  in  DATA_W signed  ROM output; valid one cycle after `rom_addr` is sampled.
- `sample`  out  DATA_W signed  current output sample.
- `sample_valid`  out  1  `sample` holds an unconsumed value.
- `sample_ready`  in  1  consumer accepts; a transfer occurs on a posedge with `sample_valid && sample_ready`.

## Operation
- **FSM states:** IDLE, FETCH, LOAD, VALID.
- **IDLE:**
  - `sample_valid`=0.
  - `enable`=1 → FETCH. Otherwise stay.
- **FETCH:** `rom_addr`=phase is held stable for one cycle; the ROM registers it at the end of the cycle. → LOAD.
- **LOAD:**
  - `sample` <= `rom_data`.
  - `sample_valid` <= 1.
  - → VALID.
- **VALID:**
  - `sample` and `sample_valid` are held stable until a transfer.
  - On transfer: phase <= wrap(phase + f_eff); `sample_valid` <= 0; → FETCH if `enable`, else → IDLE.
- **Effective step:** f_eff = `freq` if `freq` < TABLE_LEN, else 0. An out-of-range step is treated as zero, so the output repeats the same sample.
- **Wrap:**
  - s = phase + f_eff, computed at ADDR_W+1 bits.
  - phase <= (s ≥ TABLE_LEN) ? s − TABLE_LEN : s.
  - Phase is never ≥ TABLE_LEN, so ROM entry 48000 is never addressed.
- **Enable low mid-operation:**
  - In FETCH or LOAD, the FSM completes through VALID.
  - In VALID, the pending sample waits for its handshake, then the FSM goes to IDLE.
  - Phase is retained across IDLE; no reset of phase on re-enable.
- **`sample_ready` in non-VALID states:** ignored.
- **Reset:** asynchronous. Effective immediately in any state, including mid-LOAD:
  - state=IDLE
  - phase=0, so `rom_addr`=0
  - `sample`=0
  - `sample_valid`=0

## Timing
- **Start:** `enable` sampled high at edge E in IDLE → FETCH after E, LOAD after E+1, `sample_valid` high after E+2, with `sample` = ROM[phase].
- **Steady state:** transfer at edge H → `sample_valid` low after H, new `rom_addr` visible after H, next `sample_valid` high after H+2.
- **Throughput:** with `sample_ready` tied high, one sample per 3 clocks. This is far above the 48 kHz codec rate, so the codec's ready signal paces the stream.
- **Latency:** `freq` change to audible effect is at most one sample. A new `freq` is applied at the next transfer.
- **Outputs:** `rom_addr`, `sample` and `sample_valid` are all registered; no combinational path from inputs to outputs.

## Structure
- **Package `synth_pkg`:** holds TABLE_LEN, ADDR_W and DATA_W constants and the `osc_state_t` enum (IDLE, FETCH, LOAD, VALID), shared with `sine` and future voice/mixer blocks.
- **Sub-module `phase_wrap`:** combinational. Inputs: phase, freq. Output: next phase. It applies the f_eff clamp and the modulo-TABLE_LEN wrap, and is reused by future multi-voice blocks.
- **ROM:** kept outside this block so the ROM instance can later be time-shared.

## Test plan
Bench ROM model: `rom_data` <= {7'b0, `rom_addr`}, registered, 1-cycle latency. Each sample therefore equals its phase.
- **Reset:** `reset_n` low for 3 cycles, then high with `enable`=0 → `sample_valid`=0, `sample`=0, `rom_addr`=0 throughout.
- **Basic tone:** `freq`=440, `enable`=1, `sample_ready`=1 → `sample_valid` pulses every 3 cycles, first 2 cycles after `enable` is sampled; samples are 0, 440, 880, 1320….
- **Wrap:** `freq`=30000 → samples 0, 30000, 12000, 42000, 24000, 6000. `freq`=1000 → `rom_addr` returns to 0 after exactly 48 transfers.
- **Backpressure:** `sample_ready`=0 for 10 cycles while valid with `freq`=100 → `sample`, `sample_valid`=1 and `rom_addr` all stable. Then one `sample_ready` pulse → exactly one transfer, and the next sample is +100.
- **Out-of-range step:** `freq`=50000 → every sample equals the pre-change phase.
- **Mid-operation control:**
  - `enable` dropped in FETCH → one more sample is produced and held until accepted, then IDLE, with phase retained; re-enable resumes at phase+`freq`.
  - `reset_n` asserted during LOAD → outputs clear in the same cycle with no spurious `sample_valid`.
